pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipe. Drives PC write-enable and the IF/ID control
//  inputs (en, load_use, predict_fail), plus an ID/EX bubble. Arbitrates three stall/flush sources:
//  - branch mispredict from EX
//  - load-use hazard in ID
//  - multi-cycle mul/div occupancy
// PARAMETERS
//  MD_TIMEOUT  32  max cycles in MD_WAIT before forced exit (watchdog); must be >= 2
//  CNT_W       6   width of md cycle counter; must satisfy 2^CNT_W > MD_TIMEOUT
// PORTS
//  clk           in   1   pipeline clock
//  rst_n         in   1   synchronous reset, active low
//  id_rs         in   5   rs field of instruction in ID
//  id_rt         in   5   rt field of instruction in ID
//  id_uses_rs    in   1   ID instruction reads rs
//  id_uses_rt    in   1   ID instruction reads rt
//  ex_mem_read   in   1   instruction in EX is a load
//  ex_rt         in   5   destination register of load in EX
//  predict_fail  in   1   EX branch resolution disagrees with prediction
//  md_start      in   1   mul/div issued from EX this cycle
//  md_done       in   1   mul/div result ready
//  pc_en         out  1   PC register write enable
//  if_id_en      out  1   IF/ID enable
//  load_use      out  1   IF/ID hold request
//  if_id_flush   out  1   IF/ID clear (to predict_fail input of IF/ID)
//  id_ex_flush   out  1   insert bubble into ID/EX
//  md_busy       out  1   FSM in MD_WAIT
//  md_timeout    out  1   one-cycle pulse: watchdog expired
// BEHAVIOUR
//  - State: RUN, MD_WAIT (2-bit encoding). Cycle counter md_cnt[CNT_W-1:0].
//  - All outputs combinational from state + inputs, except md_timeout (registered pulse).
//  - rst_n low at posedge: state<=RUN, md_cnt<=0, md_timeout<=0.
//  - While rst_n low, all outputs forced 0 (including pc_en and if_id_en).
//  - lu_hit = ex_mem_read & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
//  - Priority within a cycle: predict_fail > MD_WAIT hold > lu_hit > normal.
//  - predict_fail (any state): if_id_flush=1, id_ex_flush=1, pc_en=1 (PC takes corrected target),
//    if_id_en=1, load_use=0.
//    - In RUN, a simultaneous md_start is ignored; state stays RUN.
//    - In MD_WAIT, the flush takes effect, but the state and counter continue.
//  - RUN, lu_hit, no predict_fail: pc_en=0, if_id_en=0, load_use=1, id_ex_flush=1.
//    Exactly one bubble; the hazard clears when the load advances to MEM. No state change.
//  - RUN, md_start & !predict_fail: next state MD_WAIT, md_cnt<=0. Issue cycle itself is not stalled.
//  - MD_WAIT: pc_en=0, if_id_en=0, load_use=1, id_ex_flush=1, md_busy=1. md_cnt increments each cycle.
//    - md_done=1 -> RUN next cycle. The md_done cycle is still stalled; the pipe releases the following cycle.
//    - md_cnt==MD_TIMEOUT-1 without md_done -> RUN, md_timeout=1 for one cycle.
//    - md_done and timeout in the same cycle -> exit with md_timeout=0.
//    - lu_hit ignored in MD_WAIT; it is re-evaluated in RUN.
//    - md_start in MD_WAIT ignored (no nesting).
//  - Normal (RUN, no event): pc_en=1, if_id_en=1, others 0.
//  - rst_n low mid-MD_WAIT: abort to RUN, no md_timeout pulse.
//  - md_cnt never wraps: bounded by the MD_TIMEOUT exit.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs perf_lu[31:0], perf_flush[31:0], perf_md[31:0].
//    - Counts cycles with lu_hit stall, predict_fail asserted, and MD_WAIT respectively.
//    - Counters saturate at 32'hFFFF_FFFF; cleared by rst_n.
//  HAZARD_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. rst_n=0 for 2 cycles with md_start=1, predict_fail=1 -> all outputs 0;
//     after release with no events -> pc_en=1, if_id_en=1.
//  2. ex_mem_read=1, ex_rt=5, id_rs=5, id_uses_rs=1 -> one cycle of pc_en=0, load_use=1, id_ex_flush=1;
//     repeat with ex_rt=0 -> no stall.
//  3. Same load-use as test 2 plus predict_fail=1 in the same cycle -> if_id_flush=1, pc_en=1, load_use=0.
//  4. md_start pulse, md_done after 7 cycles -> md_busy high 7 cycles (including the done cycle);
//     pc_en=1 on the next cycle.
//  5. md_start, md_done never -> md_busy high exactly MD_TIMEOUT (32) cycles, then md_timeout=1 for one cycle;
//     repeat with md_done on the final cycle -> md_timeout stays 0.
//  6. With HAZARD_PERF_EN: 3 load-use stalls, 2 mispredicts, one 7-cycle md -> perf_lu=3, perf_flush=2, perf_md=7.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: mispredict flush, load-use bubble, mul/div hold.
// Optional HAZARD_PERF_EN adds saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       predict_fail,
  input  logic       md_start,
  input  logic       md_done,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       load_use,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       md_busy,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_lu,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_md,
`endif
  output logic       md_timeout
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             md_to_q, md_to_d;
  logic             lu_hit;
  logic             cnt_last;
  logic             lu_stall;

  assign lu_hit = ex_mem_read & (ex_rt != 5'd0) &
                  ((id_uses_rs & (id_rs == ex_rt)) |
                   (id_uses_rt & (id_rt == ex_rt)));

  assign cnt_last = (md_cnt_q == CNT_W'(MD_TIMEOUT - 1));

  // a load-use bubble is only taken in RUN and loses to a flush
  assign lu_stall = (state_q == RUN) & lu_hit & ~predict_fail;

  assign md_timeout = md_to_q & rst_n;

  // state, counter and timeout pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
      md_to_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      md_to_q  <= md_to_d;
    end
  end

  // next state and stall/flush outputs
  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    md_to_d     = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    load_use    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    md_busy     = 1'b0;
    unique case (state_q)
      RUN: begin
        md_cnt_d = '0;
        if (predict_fail) begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          if (lu_hit) begin
            load_use    = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
          if (md_start) begin
            state_d = MD_WAIT;
          end
        end
      end
      MD_WAIT: begin
        md_busy  = 1'b1;
        md_cnt_d = md_cnt_q + 1'b1;
        if (predict_fail) begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          load_use    = 1'b1;
          id_ex_flush = 1'b1;
        end
        if (md_done) begin
          state_d  = RUN;
          md_cnt_d = '0;
        end else if (cnt_last) begin
          state_d  = RUN;
          md_cnt_d = '0;
          md_to_d  = 1'b1;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase
    if (!rst_n) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      load_use    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      md_busy     = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  // saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lu    <= '0;
      perf_flush <= '0;
      perf_md    <= '0;
    end else begin
      if (lu_stall && perf_lu != '1)
        perf_lu <= perf_lu + 32'd1;
      if (predict_fail && perf_flush != '1)
        perf_flush <= perf_flush + 32'd1;
      if (state_q == MD_WAIT && perf_md != '1)
        perf_md <= perf_md + 32'd1;
    end
  end
`else
  logic unused_lu;
  assign unused_lu = lu_stall;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Output vector: {pc_en,if_id_en,load_use,if_id_flush,id_ex_flush,md_busy,md_timeout}
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, ex_mem_read;
  logic       predict_fail, md_start, md_done;
  logic       pc_en, if_id_en, load_use, if_id_flush;
  logic       id_ex_flush, md_busy, md_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu, perf_flush, perf_md;
`endif
  logic [6:0] outs;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [6:0] NORM = 7'b1100000;
  localparam logic [6:0] ZERO = 7'b0000000;
  localparam logic [6:0] LU   = 7'b0010100;
  localparam logic [6:0] PF   = 7'b1101100;
  localparam logic [6:0] BUSY = 7'b0010110;
  localparam logic [6:0] BPF  = 7'b1101110;
  localparam logic [6:0] TOUT = 7'b1100001;

  pipeline_hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .predict_fail (predict_fail),
    .md_start     (md_start),
    .md_done      (md_done),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .load_use     (load_use),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .md_busy      (md_busy),
`ifdef HAZARD_PERF_EN
    .perf_lu      (perf_lu),
    .perf_flush   (perf_flush),
    .perf_md      (perf_md),
`endif
    .md_timeout   (md_timeout)
  );

  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, load_use, if_id_flush,
                 id_ex_flush, md_busy, md_timeout};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
    predict_fail = 0; md_start = 0; md_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {25'd0, outs}, {25'd0, exp});
  endtask

  task automatic set_lu_rs(input logic [4:0] r);
    ex_mem_read = 1; ex_rt = r; id_rs = r; id_uses_rs = 1;
  endtask

  initial begin
    rst_n = 0;
    clr();
    md_start = 1; predict_fail = 1;
    tick(); ck("rst0", ZERO);
    tick(); ck("rst1", ZERO);
    rst_n = 1; clr();
    ck("rel", NORM);

    // load-use via rs, then load moves on
    tick(); clr(); set_lu_rs(5'd5);
    ck("lu_rs", LU);
    tick(); clr();
    ck("lu_gone", NORM);
    // x0 destination never hazards
    tick(); clr(); set_lu_rs(5'd0);
    ck("lu_x0", NORM);
    // rt path
    tick(); clr();
    ex_mem_read = 1; ex_rt = 7; id_rt = 7; id_uses_rt = 1;
    ck("lu_rt", LU);
    // matching rs but not used
    tick(); clr();
    ex_mem_read = 1; ex_rt = 9; id_rs = 9;
    ck("lu_unused", NORM);
    // not a load
    tick(); clr(); set_lu_rs(5'd9); ex_mem_read = 0;
    ck("lu_noload", NORM);
    // mispredict beats load-use
    tick(); clr(); set_lu_rs(5'd5); predict_fail = 1;
    ck("pf_lu", PF);
    // mispredict with md_start: stays in RUN
    tick(); clr(); predict_fail = 1; md_start = 1;
    ck("pf_md", PF);
    tick(); clr();
    ck("pf_md_nxt", NORM);

    // 7-cycle mul/div
    md_start = 1;
    ck("md_issue", NORM);
    tick();
    for (int i = 0; i < 7; i++) begin
      clr();
      md_done = (i == 6);
      if (i == 2) begin set_lu_rs(5'd5); md_start = 1; end
      if (i == 3) predict_fail = 1;
      ck($sformatf("md7_%0d", i), (i == 3) ? BPF : BUSY);
      tick();
    end
    clr();
    ck("md7_exit", NORM);

    // watchdog timeout
    tick(); md_start = 1; tick(); clr();
    for (int i = 0; i < 32; i++) begin
      ck($sformatf("to_%0d", i), BUSY);
      tick();
    end
    ck("to_pulse", TOUT);
    tick();
    ck("to_after", NORM);

    // done on the final cycle suppresses the pulse
    md_start = 1; tick(); clr();
    for (int i = 0; i < 32; i++) begin
      md_done = (i == 31);
      ck($sformatf("tod_%0d", i), BUSY);
      tick();
    end
    clr();
    ck("tod_exit", NORM);

    // reset on the last wait cycle aborts without pulse
    tick(); md_start = 1; tick(); clr();
    for (int i = 0; i < 31; i++) tick();
    ck("ab_busy", BUSY);
    rst_n = 0;
    ck("ab_rst", ZERO);
    tick(); rst_n = 1;
    ck("ab_rel", NORM);
    tick();
    ck("ab_nopulse", NORM);

`ifdef HAZARD_PERF_EN
    rst_n = 0; tick(); rst_n = 1; clr();
    ck("pf_rst", NORM);
    chk("perf_lu0", perf_lu, 32'd0);
    chk("perf_fl0", perf_flush, 32'd0);
    chk("perf_md0", perf_md, 32'd0);
    for (int i = 0; i < 3; i++) begin
      set_lu_rs(5'd3); tick(); clr(); tick();
    end
    for (int i = 0; i < 2; i++) begin
      predict_fail = 1; tick(); clr();
    end
    md_start = 1; tick(); clr();
    for (int i = 0; i < 7; i++) begin
      md_done = (i == 6); tick();
    end
    clr(); tick();
    chk("perf_lu", perf_lu, 32'd3);
    chk("perf_flush", perf_flush, 32'd2);
    chk("perf_md", perf_md, 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
